cordic_sched: RTL and testbench
===============================

# cordic_sched

Round-robin scheduler sharing one pipelined CORDIC vectoring core among NREQ requesters. Accepts at most one (x, y) job per cycle and registers it into the core. Tracks each job's requester ID through a fixed-latency tag pipeline and returns (r, phi, eps) to the originating requester. Also provides a flush/drain sequence used before reconfiguration or power-down of the core.

## Interface
- W, 7: operand/result MSB index; all data is W+1 bits signed.
- NREQ, 4: number of requesters, 2..8.
- LAT, 8: CORDIC core latency in cycles, from input sample edge to result valid; ≥1.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting low clears all state immediately.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  one-hot or zero grant; a handshake is req_valid[i] & req_ready[i].
- req_x, req_y  in  NREQ*(W+1)  packed operands; requester i occupies bits [i*(W+1) +: W+1].
- cor_x, cor_y  out  W+1  registered operands to core.
- cor_r, cor_phi, cor_eps  in  W+1  core results.
- rsp_valid  out  NREQ  one-hot result strobe; no backpressure.
- rsp_r, rsp_phi, rsp_eps  out  W+1  registered results, shared by all requesters.
- flush  in  1  level request to stop accepting jobs and drain.
- flush_done  out  1  one-cycle pulse when the drain is complete.
- busy  out  1  high while any job is in flight.

## Operation
- Reset values: req_ready=0, cor_x=cor_y=0, rsp_valid=0, rsp_*=0, flush_done=0, busy=0, RR pointer=0, FSM=RUN, tag pipe cleared.
- FSM states and transitions:
  - RUN: grants enabled. If flush=1, go to DRAIN and issue no grant that cycle.
  - DRAIN: no grants. When the in-flight count reaches 0, pulse flush_done and go to HOLD.
  - HOLD: no grants. When flush=0, go to RUN.
  - If flush rises while the pipeline is already empty, the sequence is RUN→DRAIN→HOLD with flush_done on the first DRAIN cycle.
- Arbitration (RUN only):
  - Combinational grant to the first i with req_valid[i] set, searching from the RR pointer upward and wrapping modulo NREQ.
  - req_ready is one-hot and depends on req_valid; requesters must not make valid depend on ready.
  - After a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer is held.
- Issue: on a handshake, cor_x/cor_y load the granted operands. Otherwise they hold their last value; the core output is ignored via the tag.
- Tag pipe: LAT+1 stages of {valid, id[$clog2(NREQ)-1:0]}. Stage 0 loads {handshake, granted id}.
- Response:
  - When the final tag stage is valid, register cor_r/phi/eps into rsp_* and set rsp_valid[id]=1 for one cycle.
  - Otherwise rsp_valid=0 and rsp_* hold their values.
- In-flight counter: width $clog2(LAT+3).
  - +1 on handshake, −1 on response; both in one cycle leaves it unchanged.
  - busy = (count≠0).
- Reset mid-operation: all in-flight jobs are discarded silently; no rsp_valid is emitted for them.

## Timing
- Handshake in cycle t → cor_x/cor_y valid from edge t+1 → core result at edge t+1+LAT → rsp_valid high in cycle t+LAT+2.
- Total latency is LAT+2 cycles. Throughput is 1 job/cycle, and responses are in issue order.
- flush_done pulses in the cycle after the last rsp_valid of the drained jobs.
- req_ready is low throughout DRAIN and HOLD, and low in the cycle flush is first sampled high.

## Structure
- Package cordic_pkg holds:
  - W default, idw(NREQ) function, and the tag struct {valid, id}.
  - FSM enum {RUN, DRAIN, HOLD}.
- Sub-module rr_arbiter (NREQ): req vector and pointer in, one-hot grant plus encoded id out; purely combinational. Pointer register stays in cordic_sched.
- The CORDIC core is instantiated by the parent, not inside this block.

## Test plan
- Single job: NREQ=4, LAT=8, requester 2 sends x=3, y=4 with a stub core returning r=5 → rsp_valid=4'b0100 in cycle t+10, rsp_r=5; busy high for the cycles in between.
- All four requesters valid continuously from pointer 0 → grants 0,1,2,3,0,… one per cycle; responses return in the same order, one per cycle with no bubbles.
- Requesters 1 and 3 valid, pointer at 2 → grant 3 first, then 1; pointer ends at 2.
- flush asserted with 5 jobs in flight → req_ready=0 the same cycle; 5 responses arrive; flush_done pulses once, the cycle after the last response; no grants until flush=0.
- reset driven low with 3 jobs in flight, released 2 cycles later → no rsp_valid at any time afterwards; busy=0; first new job is granted to requester 0.
- Handshake and response in the same cycle at steady state → in-flight count constant and busy stays 1.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, tag type and FSM encoding for the CORDIC request scheduler.
package cordic_pkg;

  localparam int unsigned DefW   = 7;
  // Widest requester id (NREQ <= 8); narrower configs zero-extend into it.
  localparam int unsigned IdMaxW = 3;

  function automatic int unsigned idw(input int unsigned nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  typedef struct packed {
    logic              valid;
    logic [IdMaxW-1:0] id;
  } tag_t;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHold
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the pointer, wrapping.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IdW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IdW-1:0]  o_id
);

  logic [IdW:0]   w_sum;
  logic [IdW-1:0] w_idx;
  logic           w_found;

  always_comb begin
    o_gnt   = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_sum = {1'b0, i_ptr} + (IdW + 1)'(k);
      if (w_sum >= (IdW + 1)'(NREQ)) begin
        w_sum = w_sum - (IdW + 1)'(NREQ);
      end
      w_idx = w_sum[IdW-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Round-robin front end sharing one pipelined CORDIC vectoring core among NREQ requesters,
// with an id tag pipe to route results back and a flush/drain handshake.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int unsigned W    = DefW,
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*(W+1)-1:0] req_x,
  input  logic [NREQ*(W+1)-1:0] req_y,
  output logic [W:0]            cor_x,
  output logic [W:0]            cor_y,
  input  logic [W:0]            cor_r,
  input  logic [W:0]            cor_phi,
  input  logic [W:0]            cor_eps,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [W:0]            rsp_r,
  output logic [W:0]            rsp_phi,
  output logic [W:0]            rsp_eps,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy
);

  localparam int unsigned IdW  = idw(NREQ);
  localparam int unsigned CntW = $clog2(LAT + 3);

  sched_state_e    r_state, w_state_next;
  logic [IdW-1:0]  r_ptr;
  logic [W:0]      r_cor_x, r_cor_y;
  tag_t            r_tag [LAT+1];
  logic [NREQ-1:0] r_rsp_valid;
  logic [W:0]      r_rsp_r, r_rsp_phi, r_rsp_eps;
  logic [CntW-1:0] r_cnt, w_cnt_next;

  logic [NREQ-1:0] w_gnt;
  logic [IdW-1:0]  w_gid;
  logic            w_grant_en;
  logic            w_hs;
  logic            w_rsp_any;
  logic [W:0]      w_sel_x, w_sel_y;

  rr_arbiter #(
    .NREQ (NREQ),
    .IdW  (IdW)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_id  (w_gid)
  );

  // Grants are suppressed in the very cycle flush is first seen.
  assign w_grant_en = (r_state == StRun) && !flush;
  assign req_ready  = w_grant_en ? w_gnt : '0;
  assign w_hs       = w_grant_en && (|w_gnt);
  assign w_rsp_any  = |r_rsp_valid;
  assign w_sel_x    = req_x[int'(w_gid) * int'(W + 1) +: W + 1];
  assign w_sel_y    = req_y[int'(w_gid) * int'(W + 1) +: W + 1];

  always_comb begin
    w_state_next = r_state;
    flush_done   = 1'b0;
    case (r_state)
      StRun: begin
        if (flush) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (r_cnt == '0) begin
          flush_done   = 1'b1;
          w_state_next = StHold;
        end
      end
      StHold: begin
        if (!flush) begin
          w_state_next = StRun;
        end
      end
      default: w_state_next = StRun;
    endcase
  end

  // A job stays counted up to and including its rsp_valid cycle.
  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_hs, w_rsp_any})
      2'b10:   w_cnt_next = r_cnt + CntW'(1);
      2'b01:   w_cnt_next = r_cnt - CntW'(1);
      default: w_cnt_next = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StRun;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_cor_x <= '0;
      r_cor_y <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_hs) begin
        r_ptr   <= (w_gid == IdW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
        r_cor_x <= w_sel_x;
        r_cor_y <= w_sel_y;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= int'(LAT); k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: w_hs, id: IdMaxW'(w_gid)};
      for (int k = 1; k <= int'(LAT); k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= '0;
      r_rsp_r     <= '0;
      r_rsp_phi   <= '0;
      r_rsp_eps   <= '0;
    end else if (r_tag[LAT].valid) begin
      r_rsp_valid <= NREQ'(1) << r_tag[LAT].id;
      r_rsp_r     <= cor_r;
      r_rsp_phi   <= cor_phi;
      r_rsp_eps   <= cor_eps;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign cor_x     = r_cor_x;
  assign cor_y     = r_cor_y;
  assign rsp_valid = r_rsp_valid;
  assign rsp_r     = r_rsp_r;
  assign rsp_phi   = r_rsp_phi;
  assign rsp_eps   = r_rsp_eps;
  assign busy      = (r_cnt != '0);

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: stub core, queue-based reference model, table and directed sequences.
module tb_cordic_sched;

  localparam int W    = 7;
  localparam int NREQ = 4;
  localparam int LAT  = 8;
  localparam int DW   = W + 1;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_x, req_y;
  logic [W:0]           cor_x, cor_y, cor_r, cor_phi, cor_eps;
  logic [NREQ-1:0]      rsp_valid;
  logic [W:0]           rsp_r, rsp_phi, rsp_eps;
  logic                 flush, flush_done, busy;

  cordic_sched #(
    .W    (W),
    .NREQ (NREQ),
    .LAT  (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .cor_x      (cor_x),
    .cor_y      (cor_y),
    .cor_r      (cor_r),
    .cor_phi    (cor_phi),
    .cor_eps    (cor_eps),
    .rsp_valid  (rsp_valid),
    .rsp_r      (rsp_r),
    .rsp_phi    (rsp_phi),
    .rsp_eps    (rsp_eps),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] f_r(input logic [7:0] x, input logic [7:0] y);
    return x + {y[7], y[7:1]};
  endfunction

  // Stub core: fixed LAT-cycle pipeline of simple functions of (x, y).
  logic [7:0] pr [LAT];
  logic [7:0] pp [LAT];
  logic [7:0] pe [LAT];
  always @(posedge clk) begin
    pr[0] <= f_r(cor_x, cor_y);
    pp[0] <= cor_x - cor_y;
    pe[0] <= cor_x ^ cor_y;
    for (int k = 1; k < LAT; k++) begin
      pr[k] <= pr[k-1];
      pp[k] <= pp[k-1];
      pe[k] <= pe[k-1];
    end
  end
  assign cor_r   = pr[LAT-1];
  assign cor_phi = pp[LAT-1];
  assign cor_eps = pe[LAT-1];

  typedef struct {
    int         issue;
    int         due;
    int         id;
    logic [7:0] r;
    logic [7:0] phi;
    logic [7:0] eps;
  } job_t;

  typedef struct {
    logic [NREQ-1:0] vld;
    logic [NREQ-1:0] gnt;
  } arb_vec_t;

  job_t       q[$];
  arb_vec_t   arb_tab[8];
  logic [7:0] ox[NREQ];
  logic [7:0] oy[NREQ];
  int         m_ptr, m_mode;  // mode: 0 accepting, 1 draining, 2 holding
  logic [7:0] m_r, m_phi, m_eps, m_cx, m_cy;
  int         cyc, total, bad;
  int         n_rsp, n_done, last_rsp_cyc, done_cyc;
  logic [7:0] seen_r;
  logic [NREQ-1:0] seen_vld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*DW +: DW] = ox[i];
      req_y[i*DW +: DW] = oy[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      ox[i] = 8'($urandom);
      oy[i] = 8'($urandom);
    end
    set_ops();
  endtask

  // Called shortly after a rising edge with inputs set; checks at the falling edge.
  task automatic run_cycle();
    int              g;
    int              inflight;
    logic [NREQ-1:0] eg, eg_rsp;
    job_t            j;
    @(negedge clk);
    if (!reset) begin
      q.delete();
      m_ptr = 0; m_mode = 0;
      m_r = 0; m_phi = 0; m_eps = 0; m_cx = 0; m_cy = 0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_cor", {16'd0, cor_x, cor_y}, 32'd0);
      chk("rst_rsp", {8'd0, rsp_r, rsp_phi, rsp_eps}, 32'd0);
    end else begin
      eg_rsp = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        eg_rsp = NREQ'(1 << q[0].id);
        m_r = q[0].r; m_phi = q[0].phi; m_eps = q[0].eps;
      end
      inflight = 0;
      foreach (q[i]) if (q[i].issue < cyc) inflight++;
      g = -1;
      if (m_mode == 0 && !flush) begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[i]) g = i;
        end
      end
      eg = (g < 0) ? '0 : NREQ'(1 << g);
      chk("req_ready", 32'(req_ready), 32'(eg));
      chk("rsp_valid", 32'(rsp_valid), 32'(eg_rsp));
      chk("rsp_r", 32'(rsp_r), 32'(m_r));
      chk("rsp_phi", 32'(rsp_phi), 32'(m_phi));
      chk("rsp_eps", 32'(rsp_eps), 32'(m_eps));
      chk("busy", 32'(busy), 32'(inflight != 0));
      chk("flush_done", 32'(flush_done), 32'(m_mode == 1 && inflight == 0));
      chk("cor_xy", {16'd0, cor_x, cor_y}, {16'd0, m_cx, m_cy});
      if (rsp_valid != 0) begin
        n_rsp++; last_rsp_cyc = cyc; seen_r = rsp_r; seen_vld = rsp_valid;
      end
      if (flush_done) begin
        n_done++; done_cyc = cyc;
      end
      if (eg_rsp != 0) void'(q.pop_front());
      if (g >= 0) begin
        j.issue = cyc; j.due = cyc + LAT + 2; j.id = g;
        j.r = f_r(ox[g], oy[g]); j.phi = ox[g] - oy[g]; j.eps = ox[g] ^ oy[g];
        q.push_back(j);
        m_ptr = (g + 1) % NREQ;
        m_cx = ox[g]; m_cy = oy[g];
      end
      case (m_mode)
        0: if (flush) m_mode = 1;
        1: if (inflight == 0) m_mode = 2;
        default: if (!flush) m_mode = 0;
      endcase
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) run_cycle();
  endtask

  initial begin
    int t0, n0, d0, f0;
    arb_tab[0] = '{4'b1111, 4'b0001};
    arb_tab[1] = '{4'b1111, 4'b0010};
    arb_tab[2] = '{4'b1010, 4'b1000};
    arb_tab[3] = '{4'b1010, 4'b0010};
    arb_tab[4] = '{4'b0000, 4'b0000};
    arb_tab[5] = '{4'b0001, 4'b0001};
    arb_tab[6] = '{4'b0100, 4'b0100};
    arb_tab[7] = '{4'b1001, 4'b1000};

    total = 0; bad = 0; cyc = 0; n_rsp = 0; n_done = 0;
    last_rsp_cyc = -1; done_cyc = -1; seen_r = 0; seen_vld = 0;
    m_ptr = 0; m_mode = 0; m_r = 0; m_phi = 0; m_eps = 0; m_cx = 0; m_cy = 0;
    reset = 1'b0; flush = 1'b0; req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      ox[i] = 0; oy[i] = 0;
    end
    set_ops();
    @(posedge clk); #1;
    repeat (2) run_cycle();
    reset = 1'b1;

    // Arbitration table from pointer 0; entries 2-3 cover {1,3} valid with pointer at 2.
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      req_valid = arb_tab[i].vld;
      #1;
      chk("arb_tab", 32'(req_ready), 32'(arb_tab[i].gnt));
      run_cycle();
    end
    idle(LAT + 4);

    // Single job from requester 2.
    ox[2] = 8'd3; oy[2] = 8'd4; set_ops();
    req_valid = 4'b0100; t0 = cyc;
    run_cycle();
    idle(LAT + 4);
    chk("one_latency", 32'(last_rsp_cyc - t0), 32'(LAT + 2));
    chk("one_vld", 32'(seen_vld), 32'b0100);
    chk("one_r", 32'(seen_r), 32'd5);

    // Move the pointer back to 0, then all requesters continuously.
    rand_ops(); req_valid = 4'b1000; run_cycle();
    idle(LAT + 4);
    n0 = n_rsp;
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      req_valid = 4'hf;
      #1;
      chk("rr_seq", 32'(req_ready), 32'(1 << (k % NREQ)));
      run_cycle();
    end
    idle(LAT + 4);
    chk("rr_rsp_cnt", 32'(n_rsp - n0), 32'd12);

    // Flush with five jobs in flight.
    n0 = n_rsp; d0 = n_done;
    repeat (5) begin
      rand_ops(); req_valid = 4'hf; run_cycle();
    end
    flush = 1'b1;
    #1;
    chk("flush_ready0", 32'(req_ready), 32'd0);
    repeat (LAT + 8) run_cycle();
    chk("flush_rsp_cnt", 32'(n_rsp - n0), 32'd5);
    chk("flush_done_cnt", 32'(n_done - d0), 32'd1);
    chk("flush_done_at", 32'(done_cyc - last_rsp_cyc), 32'd1);
    flush = 1'b0;
    repeat (3) run_cycle();
    idle(LAT + 4);

    // Flush with an empty pipeline.
    d0 = n_done; f0 = cyc; flush = 1'b1;
    repeat (3) run_cycle();
    chk("empty_done_at", 32'(done_cyc - f0), 32'd1);
    chk("empty_done_cnt", 32'(n_done - d0), 32'd1);
    flush = 1'b0;
    idle(3);

    // Reset with three jobs in flight.
    repeat (3) begin
      rand_ops(); req_valid = 4'hf; run_cycle();
    end
    req_valid = '0; reset = 1'b0; n0 = n_rsp;
    repeat (2) run_cycle();
    reset = 1'b1;
    idle(LAT + 6);
    chk("rst_no_rsp", 32'(n_rsp - n0), 32'd0);
    rand_ops(); req_valid = 4'hf;
    #1;
    chk("rst_first_gnt", 32'(req_ready), 32'b0001);
    run_cycle();
    idle(LAT + 4);

    // Randomized traffic with occasional flush toggles and one reset.
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      req_valid = NREQ'($urandom);
      if ($urandom_range(0, 30) == 0) flush = ~flush;
      if (k == 200) reset = 1'b0;
      if (k == 202) reset = 1'b1;
      if (!reset) req_valid = '0;
      run_cycle();
    end
    flush = 1'b0;
    idle(LAT + 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
